config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LENGTH, default 64, total configuration bits in the fabric shift chain (legal range 1..4096).
REQ-002 SHALL have parameter WORD_WIDTH, default 8, width of input configuration words (legal range 1..32).
REQ-003 SHALL have port i_Clock  input  1  single clock for all logic; every output is decoded from registered state.
REQ-004 SHALL have port i_Reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_Start  input  1  level-sampled request to begin a configuration pass.
REQ-006 SHALL have port i_Abort  input  1  terminate the current pass.
REQ-007 SHALL have port i_Word  input  WORD_WIDTH  configuration word; bit 0 is shifted first.
REQ-008 SHALL have port i_WordValid  input  1  i_Word is valid.
REQ-009 SHALL have port o_WordReady  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port o_ConfigData  output  1  serial bit to the chain input.
REQ-011 SHALL have port o_ConfigShift  output  1  chain shift enable, one bit per asserted cycle.
REQ-012 SHALL have port o_ConfigLatch  output  1  one-cycle pulse that transfers the chain to the active configuration.
REQ-013 SHALL have port o_FabricReset  output  1  holds user logic in reset while not configured.
REQ-014 SHALL have port o_Busy  output  1  a pass is in progress.
REQ-015 SHALL have port o_Done  output  1  configuration complete and fabric released.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SHIFT, LATCH and DONE.
REQ-017 IDLE or DONE with i_Start=1 SHALL go to LOAD next cycle and clear the bit counter to 0; i_Start SHALL be ignored in LOAD, SHIFT and LATCH.
REQ-018 LOAD SHALL drive o_WordReady=1; on i_WordValid=1 the word SHALL be captured and the state SHALL go to SHIFT; with i_WordValid=0 the state SHALL remain LOAD indefinitely.
REQ-019 SHIFT SHALL drive o_ConfigShift=1 and o_ConfigData=word register bit 0, then shift the word register right and increment the bit counter, once per cycle.
REQ-020 SHIFT SHALL go to LATCH after bit counter value CHAIN_LENGTH-1 is shifted, otherwise to LOAD after WORD_WIDTH bits of the current word.
REQ-021 If CHAIN_LENGTH is not a multiple of WORD_WIDTH, only the low (CHAIN_LENGTH mod WORD_WIDTH) bits of the final word SHALL be shifted; the remaining bits SHALL be discarded.
REQ-022 LATCH SHALL assert o_ConfigLatch for exactly one cycle and then go to DONE.
REQ-023 o_FabricReset SHALL be 1 in every state except DONE; o_Done SHALL be 1 only in DONE; o_Busy SHALL be 1 in LOAD, SHIFT and LATCH.
REQ-024 o_ConfigShift and o_WordReady SHALL never be 1 in the same cycle; o_ConfigData SHALL be 0 outside SHIFT.
REQ-025 i_Abort=1 in any state SHALL go to IDLE next cycle with no shift or latch pulse issued.
REQ-026 Abort from DONE SHALL reassert o_FabricReset.
REQ-027 i_Abort SHALL take priority over i_Start and over a word handshake in the same cycle.
REQ-028 A restart from DONE SHALL reassert o_FabricReset on entry to LOAD.
REQ-029 The bit counter SHALL be ceil(log2(CHAIN_LENGTH+1)) bits wide and SHALL never wrap within a pass.

Reset
REQ-030 Asserting i_Reset SHALL immediately force IDLE, a zeroed counter and a zeroed word register, with o_FabricReset=1 and all other outputs 0, including mid-SHIFT.
REQ-031 After i_Reset deasserts, the first state change SHALL occur on a subsequent i_Clock rising edge.

Verification
REQ-032 CHAIN_LENGTH=12, WORD_WIDTH=8, words 0xA5 then 0x03, i_WordValid held 1, i_Start pulsed at cycle 0 -> SHIFT cycles 2-9 carry data bits 1,0,1,0,0,1,0,1; SHIFT cycles 11-14 carry 1,1,0,0; o_ConfigLatch=1 at cycle 15; o_Done=1 and o_FabricReset=0 from cycle 16.
REQ-033 Same configuration, i_WordValid held 0 for 5 cycles while in LOAD -> o_WordReady=1 and o_ConfigShift=0 throughout the stall; the bit sequence is unchanged once i_WordValid=1.
REQ-034 i_Abort asserted at the 3rd SHIFT cycle -> IDLE next cycle, no o_ConfigLatch pulse, o_FabricReset=1; a following i_Start restarts from bit 0.
REQ-035 i_Reset asserted asynchronously mid-SHIFT -> outputs reach their reset values before the next clock edge, with o_FabricReset=1 and o_Busy=0.
REQ-036 i_Start held 1 continuously through one pass -> exactly one pass runs, then DONE lasts one cycle before LOAD re-entry with o_FabricReset reasserted.
REQ-037 i_Start and i_Abort both 1 in IDLE -> the state remains IDLE.

Source files
------------

// File: rtl/config_loader.sv
// Serial configuration loader: takes words from a ready/valid stream and shifts them
// LSB-first into a fabric configuration chain, then latches it and releases fabric reset.
module config_loader #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_Abort,
  input  logic [WORD_WIDTH-1:0] i_Word,
  input  logic                  i_WordValid,
  output logic                  o_WordReady,
  output logic                  o_ConfigData,
  output logic                  o_ConfigShift,
  output logic                  o_ConfigLatch,
  output logic                  o_FabricReset,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int CNT_W  = $clog2(CHAIN_LENGTH + 1);
  localparam int WCNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
  logic [WCNT_W-1:0]       wordCnt_q, wordCnt_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      wordCnt_q <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      wordCnt_q <= wordCnt_d;
      word_q    <= word_d;
    end
  end

  // The chain-length test comes first so a short final word ends the pass early.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    wordCnt_d = wordCnt_q;
    word_d    = word_q;
    if (i_Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_Start) begin
            state_d  = LOAD;
            bitCnt_d = '0;
          end
        end
        LOAD: begin
          if (i_WordValid) begin
            word_d    = i_Word;
            wordCnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          word_d    = word_q >> 1;
          bitCnt_d  = bitCnt_q + CNT_W'(1);
          wordCnt_d = wordCnt_q + WCNT_W'(1);
          if (bitCnt_q == LAST_BIT) begin
            state_d = LATCH;
          end else if (wordCnt_q == LAST_WBIT) begin
            state_d = LOAD;
          end
        end
        LATCH:   state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_WordReady   = (state_q == LOAD);
  assign o_ConfigShift = (state_q == SHIFT);
  assign o_ConfigData  = (state_q == SHIFT) & word_q[0];
  assign o_ConfigLatch = (state_q == LATCH);
  assign o_FabricReset = (state_q != DONE);
  assign o_Done        = (state_q == DONE);
  assign o_Busy        = (state_q == LOAD) | (state_q == SHIFT) | (state_q == LATCH);

endmodule
